or1k_branch_resolve: RTL and testbench

Resolution end of the conditional-branch prediction path. Decode pushes every predicted l.bf/l.bnf into a small in-order queue. When execute delivers the real flag, the block retires the oldest entry and compares the flag with the prediction. It then emits a registered predictor-update packet and, on a mismatch, a redirect PC plus a squash of all younger queued predictions.

---
 rtl/or1k_branch_resolve.sv | 185 ++++++++++++++++++
 tb/tb_or1k_branch_resolve.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/or1k_branch_resolve.sv
// Conditional-branch resolution queue for the or1k fetch predictor.
// Retires predictions in order, trains the predictor, redirects on mispredict.
module or1k_branch_resolve #(
  parameter int OPTION_OPERAND_WIDTH = 32,
  parameter int DEPTH                = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            push_i,
  input  logic                            push_bf_i,
  input  logic                            push_predicted_flag_i,
  input  logic [OPTION_OPERAND_WIDTH-1:0] push_pc_i,
  input  logic [OPTION_OPERAND_WIDTH-1:0] push_target_i,
  output logic                            full_o,
  input  logic                            resolve_i,
  input  logic                            flag_i,
  input  logic                            flush_i,
  output logic                            empty_o,
  output logic [$clog2(DEPTH):0]          count_o,
  output logic                            update_valid_o,
  output logic [OPTION_OPERAND_WIDTH-1:0] update_pc_o,
  output logic                            update_taken_o,
  output logic                            branch_mispredict_o,
  output logic [OPTION_OPERAND_WIDTH-1:0] redirect_pc_o,
  output logic                            error_o
);

  localparam int W  = OPTION_OPERAND_WIDTH;
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [W-1:0]  SLOT_OFS = W'(8);

  typedef struct packed {
    logic [W-1:0] pc;
    logic [W-1:0] target;
    logic         is_bf;
    logic         pred;
  } entry_t;

  entry_t        mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [CW-1:0] count;

  logic [AW-1:0] rd_nxt;
  logic [AW-1:0] wr_nxt;
  logic [CW-1:0] cnt_nxt;

  entry_t        head;
  entry_t        incoming;
  logic          full;
  logic          empty;
  logic          pop;
  logic          pop_err;
  logic          put;
  logic          put_err;
  logic          taken;
  logic          mispredict;
  logic          squash;
  logic [W-1:0]  fallthrough;
  logic [W-1:0]  redirect;

  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);

  assign full_o  = full;
  assign empty_o = empty;
  assign count_o = count;

  // Head entry decode and branch outcome for the oldest prediction
  always_comb begin
    head        = mem[rd_ptr];
    taken       = head.is_bf ? flag_i : ~flag_i;
    mispredict  = (flag_i != head.pred);
    fallthrough = head.pc + SLOT_OFS;
    redirect    = taken ? head.target : fallthrough;
  end

  // Pack the decode-side branch into a queue entry
  always_comb begin
    incoming.pc     = push_pc_i;
    incoming.target = push_target_i;
    incoming.is_bf  = push_bf_i;
    incoming.pred   = push_predicted_flag_i;
  end

  // Accept/reject decisions; flush overrides everything, fullness is
  // judged on the count before this cycle's pop
  always_comb begin
    pop     = !flush_i && resolve_i && !empty;
    pop_err = !flush_i && resolve_i && empty;
    squash  = pop && mispredict;
    put     = !flush_i && push_i && !full && !squash;
    put_err = !flush_i && push_i && full;
  end

  // Pointer and occupancy next-state
  always_comb begin
    rd_nxt  = rd_ptr;
    wr_nxt  = wr_ptr;
    cnt_nxt = count;
    unique case (1'b1)
      flush_i: begin
        rd_nxt  = wr_ptr;
        cnt_nxt = '0;
      end
      squash: begin
        rd_nxt  = wr_ptr;
        cnt_nxt = '0;
      end
      default: begin
        if (pop)
          rd_nxt = rd_ptr + AW'(1);
        if (put)
          wr_nxt = wr_ptr + AW'(1);
        cnt_nxt = count + CW'(put) - CW'(pop);
      end
    endcase
  end

  // Queue control state
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      rd_ptr <= rd_nxt;
      wr_ptr <= wr_nxt;
      count  <= cnt_nxt;
    end
  end

  // Entry storage, written only on an accepted push
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++)
        mem[i] <= '0;
    end else if (put) begin
      mem[wr_ptr] <= incoming;
    end
  end

  // One-cycle training and redirect pulses
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      update_valid_o      <= 1'b0;
      branch_mispredict_o <= 1'b0;
    end else begin
      update_valid_o      <= pop;
      branch_mispredict_o <= squash;
    end
  end

  // Payload registers hold between resolves
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      update_pc_o    <= '0;
      update_taken_o <= 1'b0;
      redirect_pc_o  <= '0;
    end else if (pop) begin
      update_pc_o    <= head.pc;
      update_taken_o <= taken;
      redirect_pc_o  <= redirect;
    end
  end

  // Sticky protocol error, cleared only by reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      error_o <= 1'b0;
    else if (put_err || pop_err)
      error_o <= 1'b1;
  end

  a_count_range: assert property (
    @(posedge clk) disable iff (!rst) count <= FULL_CNT);

  a_mispredict_pulse: assert property (
    @(posedge clk) disable iff (!rst)
      branch_mispredict_o |-> update_valid_o);

endmodule

// File: tb/tb_or1k_branch_resolve.sv
// Bench for or1k_branch_resolve: queue-level reference model checked
// every cycle, plus directed literal expectations.
module tb_or1k_branch_resolve;

  localparam int W = 32;
  localparam int DEPTH = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         push_i = 1'b0;
  logic         push_bf_i = 1'b0;
  logic         push_predicted_flag_i = 1'b0;
  logic [W-1:0] push_pc_i = '0;
  logic [W-1:0] push_target_i = '0;
  logic         full_o;
  logic         resolve_i = 1'b0;
  logic         flag_i = 1'b0;
  logic         flush_i = 1'b0;
  logic         empty_o;
  logic [2:0]   count_o;
  logic         update_valid_o;
  logic [W-1:0] update_pc_o;
  logic         update_taken_o;
  logic         branch_mispredict_o;
  logic [W-1:0] redirect_pc_o;
  logic         error_o;

  int checks = 0;
  int errors = 0;

  or1k_branch_resolve #(
    .OPTION_OPERAND_WIDTH(W),
    .DEPTH(DEPTH)
  ) dut (
    .clk(clk),
    .rst(rst),
    .push_i(push_i),
    .push_bf_i(push_bf_i),
    .push_predicted_flag_i(push_predicted_flag_i),
    .push_pc_i(push_pc_i),
    .push_target_i(push_target_i),
    .full_o(full_o),
    .resolve_i(resolve_i),
    .flag_i(flag_i),
    .flush_i(flush_i),
    .empty_o(empty_o),
    .count_o(count_o),
    .update_valid_o(update_valid_o),
    .update_pc_o(update_pc_o),
    .update_taken_o(update_taken_o),
    .branch_mispredict_o(branch_mispredict_o),
    .redirect_pc_o(redirect_pc_o),
    .error_o(error_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name,
                     input logic [W-1:0] act,
                     input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: a plain FIFO of predicted branches
  typedef struct {
    logic [W-1:0] pc;
    logic [W-1:0] tgt;
    logic         bf;
    logic         pf;
  } ent_t;

  ent_t         q[$];
  logic         m_valid = 1'b0;
  logic         m_mis = 1'b0;
  logic         m_err = 1'b0;
  logic         m_taken = 1'b0;
  logic [W-1:0] m_pc = '0;
  logic [W-1:0] m_redir = '0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      q.delete();
      m_valid = 1'b0;
      m_mis = 1'b0;
      m_err = 1'b0;
      m_taken = 1'b0;
      m_pc = '0;
      m_redir = '0;
    end else begin
      ent_t e;
      logic was_full;
      logic dropped;
      m_valid = 1'b0;
      m_mis = 1'b0;
      dropped = 1'b0;
      was_full = (q.size() == DEPTH);
      if (flush_i) begin
        q.delete();
      end else begin
        if (resolve_i) begin
          if (q.size() == 0) begin
            m_err = 1'b1;
          end else begin
            e = q.pop_front();
            m_valid = 1'b1;
            m_pc = e.pc;
            m_taken = e.bf ? flag_i : !flag_i;
            m_redir = m_taken ? e.tgt : e.pc + 32'd8;
            if (flag_i != e.pf) begin
              m_mis = 1'b1;
              dropped = 1'b1;
              q.delete();
            end
          end
        end
        if (push_i) begin
          if (was_full) begin
            m_err = 1'b1;
          end else if (!dropped) begin
            e.pc = push_pc_i;
            e.tgt = push_target_i;
            e.bf = push_bf_i;
            e.pf = push_predicted_flag_i;
            q.push_back(e);
          end
        end
      end
    end
  end

  // Compare the DUT against the model once per cycle, away from the edge
  always @(negedge clk) begin
    chk("m_count", 32'(count_o), 32'(q.size()));
    chk("m_empty", 32'(empty_o), 32'(q.size() == 0));
    chk("m_full", 32'(full_o), 32'(q.size() == DEPTH));
    chk("m_valid", 32'(update_valid_o), 32'(m_valid));
    chk("m_mis", 32'(branch_mispredict_o), 32'(m_mis));
    chk("m_err", 32'(error_o), 32'(m_err));
    chk("m_taken", 32'(update_taken_o), 32'(m_taken));
    chk("m_upc", update_pc_o, m_pc);
    chk("m_redir", redirect_pc_o, m_redir);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic p, input logic bf, input logic pf,
                       input logic [W-1:0] pc, input logic [W-1:0] tgt,
                       input logic r, input logic f, input logic fl);
    push_i = p;
    push_bf_i = bf;
    push_predicted_flag_i = pf;
    push_pc_i = pc;
    push_target_i = tgt;
    resolve_i = r;
    flag_i = f;
    flush_i = fl;
  endtask

  task automatic idle();
    drive(0, 0, 0, '0, '0, 0, 0, 0);
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b0;
    tick();
    tick();
    @(posedge clk);
    #1 rst = 1'b1;
    tick();
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    #1 rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    chk("rst_empty", 32'(empty_o), 32'd1);
    chk("rst_count", 32'(count_o), 32'd0);
    chk("rst_err", 32'(error_o), 32'd0);
    chk("rst_valid", 32'(update_valid_o), 32'd0);

    // correct l.bf prediction
    drive(1, 1, 1, 32'h100, 32'h200, 0, 0, 0);
    tick();
    drive(0, 0, 0, '0, '0, 1, 1, 0);
    tick();
    chk("ok_valid", 32'(update_valid_o), 32'd1);
    chk("ok_pc", update_pc_o, 32'h100);
    chk("ok_taken", 32'(update_taken_o), 32'd1);
    chk("ok_mis", 32'(branch_mispredict_o), 32'd0);
    chk("ok_count", 32'(count_o), 32'd0);

    // l.bnf correctly predicted not-set, then mispredicted
    drive(1, 0, 0, 32'h40, 32'h80, 0, 0, 0);
    tick();
    drive(0, 0, 0, '0, '0, 1, 0, 0);
    tick();
    chk("bnf_taken", 32'(update_taken_o), 32'd1);
    chk("bnf_mis", 32'(branch_mispredict_o), 32'd0);
    drive(1, 0, 1, 32'h40, 32'h80, 0, 0, 0);
    tick();
    drive(0, 0, 0, '0, '0, 1, 0, 0);
    tick();
    chk("bnf2_mis", 32'(branch_mispredict_o), 32'd1);
    chk("bnf2_redir", redirect_pc_o, 32'h80);
    idle();
    tick();
    chk("pulse_drop", 32'(update_valid_o), 32'd0);
    chk("redir_hold", redirect_pc_o, 32'h80);

    // fallthrough mispredict squashes queue and same-cycle push
    for (int i = 0; i < 3; i++) begin
      drive(1, 1, 1, 32'h300 + 32'(i) * 32'h10, 32'h900, 0, 0, 0);
      tick();
    end
    chk("sq_count3", 32'(count_o), 32'd3);
    drive(1, 1, 1, 32'h330, 32'h990, 1, 0, 0);
    tick();
    chk("sq_redir", redirect_pc_o, 32'h308);
    chk("sq_mis", 32'(branch_mispredict_o), 32'd1);
    chk("sq_count", 32'(count_o), 32'd0);
    idle();
    tick();
    chk("sq_count2", 32'(count_o), 32'd0);
    chk("sq_noerr", 32'(error_o), 32'd0);

    // fill, overflow, then drain across pointer wrap
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(1, 1, 1, 32'h1000 + 32'(i) * 32'h10, 32'h2000, 0, 0, 0);
      tick();
    end
    chk("fill_full", 32'(full_o), 32'd1);
    chk("fill_err0", 32'(error_o), 32'd0);
    drive(1, 1, 1, 32'h1f00, 32'h2000, 0, 0, 0);
    tick();
    chk("ovf_err", 32'(error_o), 32'd1);
    chk("ovf_count", 32'(count_o), 32'd4);
    drive(0, 0, 0, '0, '0, 1, 1, 0);
    tick();
    chk("drain_pc0", update_pc_o, 32'h1000);
    chk("drain_cnt", 32'(count_o), 32'd3);
    for (int i = 0; i < 6; i++) begin
      drive(1, 1, 1, 32'h1100 + 32'(i) * 32'h10, 32'h2000, 1, 1, 0);
      tick();
    end
    chk("pair_pc", update_pc_o, 32'h1120);
    chk("pair_cnt", 32'(count_o), 32'd3);
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 0, '0, '0, 1, 1, 0);
      tick();
    end
    chk("last_pc", update_pc_o, 32'h1150);
    chk("last_empty", 32'(empty_o), 32'd1);
    idle();
    tick();

    // flush beats resolve; then resolve on empty
    do_reset();
    for (int i = 0; i < 2; i++) begin
      drive(1, 0, 0, 32'h500 + 32'(i) * 32'h4, 32'h600, 0, 0, 0);
      tick();
    end
    drive(0, 0, 0, '0, '0, 1, 1, 1);
    tick();
    chk("fl_count", 32'(count_o), 32'd0);
    chk("fl_valid", 32'(update_valid_o), 32'd0);
    chk("fl_err", 32'(error_o), 32'd0);
    drive(0, 0, 0, '0, '0, 1, 1, 0);
    tick();
    chk("emp_err", 32'(error_o), 32'd1);
    chk("emp_valid", 32'(update_valid_o), 32'd0);

    // asynchronous reset mid-cycle
    for (int i = 0; i < 2; i++) begin
      drive(1, 1, 0, 32'h700 + 32'(i) * 32'h4, 32'h800, 0, 0, 0);
      tick();
    end
    idle();
    #2 rst = 1'b0;
    #1;
    chk("ar_count", 32'(count_o), 32'd0);
    chk("ar_err", 32'(error_o), 32'd0);
    chk("ar_empty", 32'(empty_o), 32'd1);
    @(posedge clk);
    #1 rst = 1'b1;
    tick();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
